// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage CPU pipeline registers.
// The control bundle layout is common to ID/EX, EX/MEM and MEM/WB.
package cpu_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_RW_W   = 5;

   // Control-bundle bit positions
   localparam int JUMP     = 0;
   localparam int BRANCH   = 1;
   localparam int MEMWR    = 2;
   localparam int REGWR    = 3;
   localparam int MEMTOREG = 4;
   localparam int CTRL_W   = 5;

   typedef logic [CTRL_W-1:0] ctrl_t;

   // Pack individual control lines into the shared bundle layout
   function automatic ctrl_t pack_ctrl(input logic jump, input logic branch,
                                       input logic memwr, input logic regwr,
                                       input logic memtoreg);
      ctrl_t c;
      c           = '0;
      c[JUMP]     = jump;
      c[BRANCH]   = branch;
      c[MEMWR]    = memwr;
      c[REGWR]    = regwr;
      c[MEMTOREG] = memtoreg;
      return c;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter, clocked on the falling edge like the pipeline.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Inc,
   output logic [W-1:0] Count
);

   localparam logic [W-1:0] MAX_CNT = '1;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
      if (v == MAX_CNT) return v;
      return v + 1'b1;
   endfunction

   // Count events; only Reset brings the value back to zero
   always_ff @(negedge Clk) begin
      if (Reset)    Count <= '0;
      else if (Inc) Count <= sat_inc(Count);
   end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with valid, stall/flush, overflow and $0 write
// kill, plus saturating bubble and stall counters.
import cpu_pkg::*;

module ex_mem_pipe_reg #(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int RW_W         = DEF_RW_W,
   parameter int CNT_W        = 16,
   parameter bit KILL_ON_OVF  = 1'b1,
   parameter bit ZERO_RW_KILL = 1'b1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Stall,
   input  logic              Flush,
   input  logic              E_Valid,
   input  logic [DATA_W-1:0] E_Jtarg,
   input  logic [DATA_W-1:0] E_Btarg,
   input  logic              E_Zero,
   input  logic              E_Overflow,
   input  logic [DATA_W-1:0] E_ALUout,
   input  logic [DATA_W-1:0] E_busB,
   input  logic [RW_W-1:0]   E_Rw,
   input  logic              E_Jump,
   input  logic              E_Branch,
   input  logic              E_MemWr,
   input  logic              E_RegWr,
   input  logic              E_MemtoReg,
   output logic              M_Valid,
   output logic [DATA_W-1:0] M_Jtarg,
   output logic [DATA_W-1:0] M_Btarg,
   output logic              M_Zero,
   output logic              M_Overflow,
   output logic [DATA_W-1:0] M_ALUout,
   output logic [DATA_W-1:0] M_busB,
   output logic [RW_W-1:0]   M_Rw,
   output logic              M_Jump,
   output logic              M_Branch,
   output logic              M_MemWr,
   output logic              M_RegWr,
   output logic              M_MemtoReg,
   output logic [CNT_W-1:0]  BubbleCnt,
   output logic [CNT_W-1:0]  StallCnt
);

   ctrl_t ctrl_in;
   ctrl_t ctrl_nxt;
   ctrl_t ctrl_p1;
   logic  vld_p1;
   logic  bubble_inc;
   logic  stall_inc;

   assign ctrl_in = pack_ctrl(E_Jump, E_Branch, E_MemWr, E_RegWr, E_MemtoReg);

   // Filter control: bubbles carry no control, overflow and $0 kill writes
   always_comb begin
      ctrl_nxt = '0;
      if (E_Valid) begin
         ctrl_nxt = ctrl_in;
         if (KILL_ON_OVF && E_Overflow) begin
            ctrl_nxt[REGWR]    = 1'b0;
            ctrl_nxt[MEMWR]    = 1'b0;
            ctrl_nxt[MEMTOREG] = 1'b0;
         end
         if (ZERO_RW_KILL && (E_Rw == '0))
            ctrl_nxt[REGWR] = 1'b0;
      end
   end

   // EX -> MEM stage boundary: Reset > Flush > Stall > load
   always_ff @(negedge Clk) begin
      if (Reset || Flush) begin
         vld_p1     <= 1'b0;
         ctrl_p1    <= '0;
         M_Jtarg    <= '0;
         M_Btarg    <= '0;
         M_Zero     <= 1'b0;
         M_Overflow <= 1'b0;
         M_ALUout   <= '0;
         M_busB     <= '0;
         M_Rw       <= '0;
      end else if (!Stall) begin
         vld_p1     <= E_Valid;
         ctrl_p1    <= ctrl_nxt;
         M_Jtarg    <= E_Jtarg;
         M_Btarg    <= E_Btarg;
         M_Zero     <= E_Zero;
         M_Overflow <= E_Overflow;
         M_ALUout   <= E_ALUout;
         M_busB     <= E_busB;
         M_Rw       <= E_Rw;
      end
   end

   assign M_Valid    = vld_p1;
   assign M_Jump     = ctrl_p1[JUMP];
   assign M_Branch   = ctrl_p1[BRANCH];
   assign M_MemWr    = ctrl_p1[MEMWR];
   assign M_RegWr    = ctrl_p1[REGWR];
   assign M_MemtoReg = ctrl_p1[MEMTOREG];

   // A bubble is either a flush or a load of an invalid EX slot
   assign bubble_inc = Flush || (!Stall && !E_Valid);
   assign stall_inc  = Stall && !Flush;

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .Clk   (Clk),
      .Reset (Reset),
      .Inc   (bubble_inc),
      .Count (BubbleCnt)
   );

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .Clk   (Clk),
      .Reset (Reset),
      .Inc   (stall_inc),
      .Count (StallCnt)
   );

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench for ex_mem_pipe_reg: default instance, a no-overflow-kill
// instance and a 4-bit-counter instance share one stimulus stream.
module tb_ex_mem_pipe_reg;

   logic        Clk;
   logic        Reset, Stall, Flush, E_Valid;
   logic [31:0] E_Jtarg, E_Btarg, E_ALUout, E_busB;
   logic        E_Zero, E_Overflow;
   logic [4:0]  E_Rw;
   logic        E_Jump, E_Branch, E_MemWr, E_RegWr, E_MemtoReg;

   logic        a_Valid, a_Zero, a_Ovf, a_Jump, a_Branch, a_MemWr, a_RegWr, a_M2R;
   logic [31:0] a_Jtarg, a_Btarg, a_ALUout, a_busB;
   logic [4:0]  a_Rw;
   logic [15:0] a_Bub, a_Stl;

   logic        b_Valid, b_Zero, b_Ovf, b_Jump, b_Branch, b_MemWr, b_RegWr, b_M2R;
   logic [31:0] b_Jtarg, b_Btarg, b_ALUout, b_busB;
   logic [4:0]  b_Rw;
   logic [15:0] b_Bub, b_Stl;

   logic        c_Valid, c_Zero, c_Ovf, c_Jump, c_Branch, c_MemWr, c_RegWr, c_M2R;
   logic [31:0] c_Jtarg, c_Btarg, c_ALUout, c_busB;
   logic [4:0]  c_Rw;
   logic [3:0]  c_Bub, c_Stl;

   int checks = 0;
   int errors = 0;

   ex_mem_pipe_reg u_dut (
      .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .E_Valid(E_Valid),
      .E_Jtarg(E_Jtarg), .E_Btarg(E_Btarg), .E_Zero(E_Zero), .E_Overflow(E_Overflow),
      .E_ALUout(E_ALUout), .E_busB(E_busB), .E_Rw(E_Rw), .E_Jump(E_Jump),
      .E_Branch(E_Branch), .E_MemWr(E_MemWr), .E_RegWr(E_RegWr), .E_MemtoReg(E_MemtoReg),
      .M_Valid(a_Valid), .M_Jtarg(a_Jtarg), .M_Btarg(a_Btarg), .M_Zero(a_Zero),
      .M_Overflow(a_Ovf), .M_ALUout(a_ALUout), .M_busB(a_busB), .M_Rw(a_Rw),
      .M_Jump(a_Jump), .M_Branch(a_Branch), .M_MemWr(a_MemWr), .M_RegWr(a_RegWr),
      .M_MemtoReg(a_M2R), .BubbleCnt(a_Bub), .StallCnt(a_Stl)
   );

   ex_mem_pipe_reg #(.KILL_ON_OVF(1'b0)) u_nokill (
      .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .E_Valid(E_Valid),
      .E_Jtarg(E_Jtarg), .E_Btarg(E_Btarg), .E_Zero(E_Zero), .E_Overflow(E_Overflow),
      .E_ALUout(E_ALUout), .E_busB(E_busB), .E_Rw(E_Rw), .E_Jump(E_Jump),
      .E_Branch(E_Branch), .E_MemWr(E_MemWr), .E_RegWr(E_RegWr), .E_MemtoReg(E_MemtoReg),
      .M_Valid(b_Valid), .M_Jtarg(b_Jtarg), .M_Btarg(b_Btarg), .M_Zero(b_Zero),
      .M_Overflow(b_Ovf), .M_ALUout(b_ALUout), .M_busB(b_busB), .M_Rw(b_Rw),
      .M_Jump(b_Jump), .M_Branch(b_Branch), .M_MemWr(b_MemWr), .M_RegWr(b_RegWr),
      .M_MemtoReg(b_M2R), .BubbleCnt(b_Bub), .StallCnt(b_Stl)
   );

   ex_mem_pipe_reg #(.CNT_W(4)) u_cnt4 (
      .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .E_Valid(E_Valid),
      .E_Jtarg(E_Jtarg), .E_Btarg(E_Btarg), .E_Zero(E_Zero), .E_Overflow(E_Overflow),
      .E_ALUout(E_ALUout), .E_busB(E_busB), .E_Rw(E_Rw), .E_Jump(E_Jump),
      .E_Branch(E_Branch), .E_MemWr(E_MemWr), .E_RegWr(E_RegWr), .E_MemtoReg(E_MemtoReg),
      .M_Valid(c_Valid), .M_Jtarg(c_Jtarg), .M_Btarg(c_Btarg), .M_Zero(c_Zero),
      .M_Overflow(c_Ovf), .M_ALUout(c_ALUout), .M_busB(c_busB), .M_Rw(c_Rw),
      .M_Jump(c_Jump), .M_Branch(c_Branch), .M_MemWr(c_MemWr), .M_RegWr(c_RegWr),
      .M_MemtoReg(c_M2R), .BubbleCnt(c_Bub), .StallCnt(c_Stl)
   );

   initial Clk = 1'b1;
   always #5 Clk = ~Clk;

   // Advance one capturing edge and settle
   task automatic tick();
      @(negedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      Stall = 0; Flush = 0; E_Valid = 0;
      E_Jtarg = '0; E_Btarg = '0; E_ALUout = '0; E_busB = '0;
      E_Zero = 0; E_Overflow = 0; E_Rw = '0;
      E_Jump = 0; E_Branch = 0; E_MemWr = 0; E_RegWr = 0; E_MemtoReg = 0;
   endtask

   initial begin
      clear_inputs();
      Reset = 1;
      E_ALUout = 32'hDEAD_BEEF; E_Valid = 1; E_RegWr = 1; E_Rw = 5'd3;
      tick();
      chk("rst_valid", a_Valid, 0);
      chk("rst_aluout", a_ALUout, 0);
      chk("rst_rw", a_Rw, 0);
      chk("rst_regwr", a_RegWr, 0);
      chk("rst_bubble", a_Bub, 0);
      chk("rst_stall", a_Stl, 0);

      // Plain load
      Reset = 0; clear_inputs();
      E_Valid = 1; E_ALUout = 32'h1234_5678; E_Rw = 5'd9; E_RegWr = 1;
      tick();
      chk("load_aluout", a_ALUout, 32'h1234_5678);
      chk("load_rw", a_Rw, 9);
      chk("load_regwr", a_RegWr, 1);
      chk("load_valid", a_Valid, 1);
      chk("load_bubble", a_Bub, 0);

      // Stall holds outputs for three edges
      E_ALUout = 32'hA;
      tick();
      chk("pre_stall_aluout", a_ALUout, 32'hA);
      Stall = 1; E_ALUout = 32'hB;
      tick(); tick(); tick();
      chk("stall_hold_aluout", a_ALUout, 32'hA);
      chk("stall_hold_valid", a_Valid, 1);
      chk("stall_cnt3", a_Stl, 3);
      Stall = 0;
      tick();
      chk("post_stall_aluout", a_ALUout, 32'hB);
      chk("post_stall_cnt", a_Stl, 3);

      // Flush wins over stall
      Stall = 1; Flush = 1; E_MemWr = 1; E_Valid = 1; E_busB = 32'h55;
      tick();
      chk("flush_memwr", a_MemWr, 0);
      chk("flush_valid", a_Valid, 0);
      chk("flush_busb", a_busB, 0);
      chk("flush_rw", a_Rw, 0);
      chk("flush_bubble", a_Bub, 1);
      chk("flush_stallcnt", a_Stl, 3);

      // Overflow kill, compared against the no-kill instance
      clear_inputs();
      E_Valid = 1; E_Overflow = 1; E_RegWr = 1; E_MemWr = 1; E_Branch = 1;
      E_MemtoReg = 1; E_Rw = 5'd9; E_ALUout = 32'h8000_0000;
      tick();
      chk("ovf_regwr", a_RegWr, 0);
      chk("ovf_memwr", a_MemWr, 0);
      chk("ovf_memtoreg", a_M2R, 0);
      chk("ovf_branch", a_Branch, 1);
      chk("ovf_flag", a_Ovf, 1);
      chk("ovf_valid", a_Valid, 1);
      chk("nokill_regwr", b_RegWr, 1);
      chk("nokill_memwr", b_MemWr, 1);
      chk("nokill_memtoreg", b_M2R, 1);

      // Write to $0 is suppressed, Zero flag passes through
      clear_inputs();
      E_Valid = 1; E_Rw = 5'd0; E_RegWr = 1; E_Zero = 1;
      tick();
      chk("zero_rw_regwr", a_RegWr, 0);
      chk("zero_rw_zero", a_Zero, 1);
      chk("zero_rw_valid", a_Valid, 1);

      // Invalid EX slot: control dropped, datapath still copied
      clear_inputs();
      E_Valid = 0; E_RegWr = 1; E_Rw = 5'd7; E_ALUout = 32'hC;
      tick();
      chk("inv_regwr", a_RegWr, 0);
      chk("inv_rw", a_Rw, 7);
      chk("inv_valid", a_Valid, 0);
      chk("inv_aluout", a_ALUout, 32'hC);
      chk("inv_bubble", a_Bub, 2);

      // Jump with targets
      clear_inputs();
      E_Valid = 1; E_Jump = 1; E_Jtarg = 32'h100; E_Btarg = 32'h200;
      E_Rw = 5'd3; E_RegWr = 1;
      tick();
      chk("jmp_jump", a_Jump, 1);
      chk("jmp_jtarg", a_Jtarg, 32'h100);
      chk("jmp_btarg", a_Btarg, 32'h200);
      chk("jmp_regwr", a_RegWr, 1);
      chk("jmp_zero", a_Zero, 0);

      // Counter saturation on the 4-bit instance
      clear_inputs();
      Reset = 1;
      tick();
      chk("sat_rst", c_Bub, 0);
      Reset = 0; Flush = 1;
      for (int i = 0; i < 14; i++) tick();
      chk("sat_14", c_Bub, 14);
      for (int i = 0; i < 6; i++) tick();
      chk("sat_20", c_Bub, 15);
      tick();
      chk("sat_hold", c_Bub, 15);
      chk("wide_cnt", a_Bub, 21);
      Flush = 0; Reset = 1;
      tick();
      chk("sat_clr", c_Bub, 0);
      chk("sat_clr_wide", a_Bub, 0);

      // Reset during a stall discards everything
      Reset = 0; E_Valid = 1; E_ALUout = 32'h77; E_Rw = 5'd4; E_RegWr = 1;
      tick();
      chk("pre_rst_aluout", a_ALUout, 32'h77);
      Stall = 1; Reset = 1;
      tick();
      chk("rst_stall_aluout", a_ALUout, 0);
      chk("rst_stall_valid", a_Valid, 0);
      chk("rst_stall_cnt", a_Stl, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
